// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding and port identifiers for the two-port memory arbiter.
// No logic, no latency, no backpressure.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_ICACHE = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester winner picker; a tie goes to the port not granted last.
// Latency: purely combinational. Backpressure: none, caller decides when to use the winner.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = PORT_ICACHE;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = PORT_DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) read arbiter onto one memory port; MEM_ARB_RR_EN selects round-robin ties.
// Latency: request in IDLE -> mem_req next cycle; read data forwarded combinationally on mem_ready.
// Backpressure: one transaction in flight; requesters hold req until pN_ready, mem_req holds until mem_ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic [DATA_WIDTH-1:0] p0_data,
    output logic                  p0_ready,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic [DATA_WIDTH-1:0] p1_data,
    output logic                  p1_ready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  grant_id,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  gid_q;
    logic                  winner;
    logic                  last_grant;
    logic                  grant_fire;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt1_q;

`ifdef MEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_DCACHE;
        end else if (grant_fire) begin
            last_q <= winner;
        end
    end

    assign last_grant = last_q;
`else
    // Pretending port 1 always won last makes port 0 win every tie.
    assign last_grant = PORT_DCACHE;
`endif

    arb_rr2 u_pick (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign win_addr = (winner == PORT_DCACHE) ? p1_addr : p0_addr;

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        mem_req    = 1'b0;
        p0_ready   = 1'b0;
        p1_ready   = 1'b0;
        p0_data    = '0;
        p1_data    = '0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_fire = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    // A requester that withdrew mid-flight gets no strobe; the data is dropped.
                    if (gid_q == PORT_ICACHE && p0_req) begin
                        p0_ready = 1'b1;
                        p0_data  = mem_data;
                    end
                    if (gid_q == PORT_DCACHE && p1_req) begin
                        p1_ready = 1'b1;
                        p1_data  = mem_data;
                    end
                end else begin
                    mem_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            gid_q   <= PORT_ICACHE;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                addr_q <= {win_addr[ADDR_WIDTH-1:2], 2'b00};
                gid_q  <= winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (grant_fire) begin
            if (winner == PORT_ICACHE && cnt0_q != '1) begin
                cnt0_q <= cnt0_q + CNT_WIDTH'(1);
            end
            if (winner == PORT_DCACHE && cnt1_q != '1) begin
                cnt1_q <= cnt1_q + CNT_WIDTH'(1);
            end
        end
    end

    assign busy       = (state_q == BUSY);
    assign mem_addr   = addr_q;
    assign grant_id   = gid_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction scoreboard; honours MEM_ARB_RR_EN.
// Inputs change #1 after posedge, outputs are checked on the falling edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_ready, p1_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          busy;
    logic          grant_id;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_data    (p0_data),
        .p0_ready   (p0_ready),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_data    (p1_data),
        .p1_ready   (p1_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .grant_id   (grant_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          deliver;
    } exp_t;

    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] m_cnt0, m_cnt1;
`ifdef MEM_ARB_RR_EN
    logic          m_last;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt0 = '0;
        m_cnt1 = '0;
`ifdef MEM_ARB_RR_EN
        m_last = 1'b1;
`endif
        sbq.delete();
    endtask

    function automatic logic pick(input logic r0, input logic r1);
`ifdef MEM_ARB_RR_EN
        if (r0 && r1) return ~m_last;
`else
        if (r0 && r1) return 1'b0;
`endif
        return r1;
    endfunction

    // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the following IDLE cycle.
    task automatic txn(input logic r0, input logic r1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input int lat, input logic [DW-1:0] rd, input logic drop, input logic keep);
        exp_t          e;
        exp_t          got;
        logic [AW-1:0] wa;
        int            n;
        e.port    = pick(r0, r1);
        wa        = e.port ? a1 : a0;
        e.addr    = {wa[AW-1:2], 2'b00};
        e.data    = rd;
        e.deliver = !drop;
        sbq.push_back(e);
        if (e.port == 1'b0) begin
            if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
        end else begin
            if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
        end
`ifdef MEM_ARB_RR_EN
        m_last = e.port;
`endif
        p0_req  = r0;
        p1_req  = r1;
        p0_addr = a0;
        p1_addr = a1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_mem_req", mem_req, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            if (drop) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            @(negedge clk);
            n++;
        end while (!mem_req && n < 8);
        chk("mem_req_latency", n, 1);
        for (int i = 0; i < lat; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("busy_mem_req", mem_req, 1);
            chk("busy_flag", busy, 1);
            chk("busy_mem_addr", mem_addr, e.addr);
            chk("busy_grant_id", grant_id, e.port);
            chk("busy_no_ready", {p0_ready, p1_ready}, 0);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        mem_data  = rd;
        @(negedge clk);
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
            got = sbq.pop_front();
            chk("done_mem_req", mem_req, 0);
            chk("done_busy", busy, 1);
            chk("done_p0_ready", p0_ready, (got.port == 1'b0) && got.deliver);
            chk("done_p1_ready", p1_ready, (got.port == 1'b1) && got.deliver);
            chk("done_p0_data", p0_data, ((got.port == 1'b0) && got.deliver) ? got.data : '0);
            chk("done_p1_data", p1_data, ((got.port == 1'b1) && got.deliver) ? got.data : '0);
            chk("done_cnt0", grant_cnt0, m_cnt0);
            chk("done_cnt1", grant_cnt1, m_cnt1);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_data  = '0;
        if (!keep) begin
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        p0_req    = 1'b0;
        p1_req    = 1'b0;
        p0_addr   = '0;
        p1_addr   = '0;
        mem_data  = '0;
        mem_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
        chk("rst_ready", {p0_ready, p1_ready}, 0);
        chk("rst_data", {p0_data, p1_data}, 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requests held across three back-to-back transactions.
        txn(1, 1, 32'h0000_0104, 32'h0000_0208, 1, 32'h1111_0001, 0, 1);
        txn(1, 1, 32'h0000_0104, 32'h0000_0208, 1, 32'h1111_0002, 0, 1);
        txn(1, 1, 32'h0000_0104, 32'h0000_0208, 1, 32'h1111_0003, 0, 0);
`ifdef MEM_ARB_RR_EN
        chk("tie_cnt0", grant_cnt0, 2);
        chk("tie_cnt1", grant_cnt1, 1);
`else
        chk("tie_cnt0", grant_cnt0, 3);
        chk("tie_cnt1", grant_cnt1, 0);
`endif

        txn(1, 0, 32'h0000_1003, 32'h0, 1, 32'hDEAD_BEEF, 0, 0);
        txn(0, 1, 32'h0, 32'h0000_3006, 2, 32'h5555_AAAA, 1, 0);
        txn(0, 1, 32'h0, 32'h0000_4001, 5, 32'h0BAD_F00D, 0, 0);

        // Stray mem_ready while idle produces nothing.
        mem_ready = 1'b1;
        mem_data  = 32'h7777_7777;
        @(negedge clk);
        chk("idle_rdy_ready", {p0_ready, p1_ready}, 0);
        chk("idle_rdy_data", {p0_data, p1_data}, 0);
        chk("idle_rdy_busy", busy, 0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_rdy_stays", busy, 0);

        // Asynchronous reset in the middle of a transaction.
        @(posedge clk);
        #1;
        p0_req  = 1'b1;
        p0_addr = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_data  = 32'hCAFE_CAFE;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", {p0_ready, p1_ready}, 0);
        chk("mid_rst_cnts", {grant_cnt0, grant_cnt1}, 0);
        chk("mid_rst_gid", grant_id, 0);
        p0_req    = 1'b0;
        mem_ready = 1'b0;
        mem_data  = '0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(0, 1, 32'h0, 32'h0000_8888, 1, 32'h1234_5678, 0, 0);

        // Counter saturation.
        force dut.cnt0_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt0_q;
        m_cnt0 = 16'hFFFE;
        @(negedge clk);
        chk("sat_preload", grant_cnt0, 16'hFFFE);
        @(posedge clk);
        #1;
        txn(1, 0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0001, 0, 0);
        txn(1, 0, 32'h0000_0020, 32'h0, 1, 32'hA5A5_0002, 0, 0);
        chk("sat_final", grant_cnt0, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; CNT_WIDTH, default 16, grant-counter width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- p0_req  in  1  port 0 (instruction cache) fetch request, level
- p0_addr  in  ADDR_WIDTH  port 0 word address
- p0_data  out  DATA_WIDTH  port 0 read data
- p0_ready  out  1  port 0 data-valid strobe
- p1_req  in  1  port 1 (data cache) fetch request, level
- p1_addr  in  ADDR_WIDTH  port 1 word address
- p1_data  out  DATA_WIDTH  port 1 read data
- p1_ready  out  1  port 1 data-valid strobe
- mem_req  out  1  downstream request
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_data  in  DATA_WIDTH  downstream read data
- mem_ready  in  1  downstream data-valid strobe
- busy  out  1  transaction outstanding
- grant_id  out  1  port owning the current transaction
- grant_cnt0  out  CNT_WIDTH  port 0 grants, saturating
- grant_cnt1  out  CNT_WIDTH  port 1 grants, saturating

Function
REQ-004 The FSM SHALL have two states: IDLE and BUSY; encodings 0 and 1.
REQ-005 IDLE: if p0_req or p1_req is high, the block SHALL select a winner, latch its address with bits [1:0] forced to zero and the winner into grant_id, increment that port's counter, and go to BUSY next cycle; otherwise stay in IDLE.
REQ-006 BUSY: mem_addr SHALL equal the latched address; mem_req SHALL be high while mem_ready is low; mem_req SHALL be low in the mem_ready cycle and in IDLE.
REQ-007 In the BUSY cycle where mem_ready is high, the granted port SHALL see pN_ready=1 and pN_data=mem_data combinationally, and the FSM SHALL return to IDLE.
REQ-008 pN_ready SHALL be zero in all other cycles and for the non-granted port; pN_data SHALL be zero when pN_ready is low.
REQ-009 Latency: a request raised in IDLE at cycle T SHALL produce mem_req at T+1; back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-010 If the granted port drops its request while BUSY, the transaction SHALL still complete downstream; the data SHALL be discarded and no pN_ready issued.
REQ-011 mem_ready in IDLE SHALL be ignored.
REQ-012 busy SHALL be 1 exactly when state is BUSY.
REQ-013 Grant counters SHALL saturate at all-ones and SHALL not wrap.

Reset
REQ-014 On rst_n low, asynchronously: state=IDLE, grant_id=0, latched address=0, last-grant=1, counters=0; hence mem_req, p0_ready, p1_ready, busy=0, all data outputs=0.
REQ-015 Reset mid-transaction SHALL abandon it with no pN_ready.

Configuration
REQ-016 With MEM_ARB_RR_EN defined: on simultaneous requests the port not granted last SHALL win; last-grant updates on every grant.
REQ-017 Without MEM_ARB_RR_EN: port 0 SHALL always win simultaneous requests; the last-grant register SHALL be omitted.

Structure
REQ-018 A shared package mem_arb_pkg SHALL hold the state encoding and the port-ID constants PORT_ICACHE=0 and PORT_DCACHE=1.
REQ-019 Winner selection SHALL be a sub-module arb_rr2: a two-requester picker taking requests and last-grant and returning the winner.

Verification
REQ-020 Benches SHALL cover these directed scenarios:
- Single p0_req, p0_addr=0x1003 -> mem_addr=0x1000 with mem_req next cycle; mem_ready with mem_data=0xDEADBEEF -> p0_ready=1, p0_data=0xDEADBEEF, p1_ready=0.
- p0_req and p1_req both high for three transactions, RR build -> grants 0,1,0 and grant_cnt0=2, grant_cnt1=1; fixed build -> grants 0,0,0.
- p1 granted, p1_req dropped before mem_ready -> no p1_ready; FSM returns to IDLE; grant_cnt1=1.
- mem_ready held low for 5 cycles -> mem_req high for 5 cycles, busy=1 throughout; mem_addr stable.
- rst_n pulsed low while BUSY -> mem_req=0 and busy=0 immediately; counters=0; next request granted normally.
- Force grant_cnt0 to all-ones minus 1, then issue two p0 grants -> counter stays 0xFFFF.
